// File: rtl/surf_train_pkg.sv
// rtl/surf_train_pkg.sv - shared types and widths for the SURF COUT training sequencer
package surf_train_pkg;

    localparam int TAP_W       = 6;
    localparam int EYE_W       = 7;
    localparam int SRST_CYCLES = 4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SRST,
        ST_LOAD,
        ST_SETTLE,
        ST_CAP,
        ST_WAIT,
        ST_EVAL,
        ST_PICK,
        ST_CLOAD,
        ST_CSETTLE,
        ST_SCAP,
        ST_SWAIT,
        ST_SLIP,
        ST_DONE,
        ST_FAIL
    } state_e;

    typedef enum logic [1:0] {
        FAIL_NONE   = 2'b00,
        FAIL_NOEYE  = 2'b01,
        FAIL_NOLOCK = 2'b10,
        FAIL_ABORT  = 2'b11
    } fail_code_e;

endpackage

// File: rtl/surf_eye_tracker.sv
// rtl/surf_eye_tracker.sv - tracks the current and longest error-free IDELAY tap window
module surf_eye_tracker
    import surf_train_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             valid,
    input  logic             good,
    input  logic [TAP_W-1:0] tap,
    output logic [TAP_W-1:0] best_start,
    output logic [EYE_W-1:0] best_len,
    output logic [TAP_W-1:0] centre
);

    logic [TAP_W-1:0] cur_start_q, cur_start_d;
    logic [EYE_W-1:0] cur_len_q, cur_len_d;
    logic [TAP_W-1:0] best_start_q, best_start_d;
    logic [EYE_W-1:0] best_len_q, best_len_d;
    logic [EYE_W-1:0] centre_full;

    // Extend the running window on a good tap; a strictly longer run replaces the best,
    // so on equal lengths the earlier window is kept.
    always_comb begin
        cur_start_d  = cur_start_q;
        cur_len_d    = cur_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        if (clear) begin
            cur_start_d  = '0;
            cur_len_d    = '0;
            best_start_d = '0;
            best_len_d   = '0;
        end else if (valid) begin
            if (good) begin
                if (cur_len_q == '0) begin
                    cur_start_d = tap;
                end
                cur_len_d = cur_len_q + 1'b1;
                if (cur_len_d > best_len_q) begin
                    best_start_d = cur_start_d;
                    best_len_d   = cur_len_d;
                end
            end else begin
                cur_len_d = '0;
            end
        end
    end

    // Window registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cur_start_q  <= '0;
            cur_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
        end else begin
            cur_start_q  <= cur_start_d;
            cur_len_q    <= cur_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
        end
    end

    // Centre of the best window, rounded down; the sum always fits in a tap value.
    always_comb begin
        centre_full = {1'b0, best_start_q} + ((best_len_q - 1'b1) >> 1);
        centre      = centre_full[TAP_W-1:0];
    end

    assign best_start = best_start_q;
    assign best_len   = best_len_q;

endmodule

// File: rtl/surf_cout_autotrain.sv
// rtl/surf_cout_autotrain.sv - IDELAY eye sweep and bitslip alignment sequencer for one COUT link
module surf_cout_autotrain
    import surf_train_pkg::*;
#(
    parameter logic [31:0] TRAIN_SEQUENCE = 32'hA55A6996,
    parameter int          SETTLE_CYCLES  = 16,
    parameter int          CAPTURE_WAIT   = 8,
    parameter int          MIN_EYE        = 4,
    parameter int          MAX_SLIPS      = 32
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             start_i,
    input  logic             live_i,
    output logic             iserdes_rst_o,
    output logic [TAP_W-1:0] idelay_value_o,
    output logic             idelay_load_o,
    output logic             bitslip_o,
    output logic             capture_o,
    input  logic [31:0]      data_i,
    input  logic             biterr_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             fail_o,
    output logic [1:0]       fail_code_o,
    output logic [TAP_W-1:0] eye_start_o,
    output logic [EYE_W-1:0] eye_len_o
);

    localparam int CNT_W  = 16;
    localparam int SLIP_W = 8;
    localparam logic [CNT_W-1:0]  SRST_LAST   = CNT_W'(SRST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SLIP_LAST   = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0]  WAIT_LAST   = CNT_W'(CAPTURE_WAIT - 1);
    localparam logic [SLIP_W-1:0] SLIP_MAX    = SLIP_W'(MAX_SLIPS);
    localparam logic [EYE_W-1:0]  EYE_MIN     = EYE_W'(MIN_EYE);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic [SLIP_W-1:0] slips_q, slips_d;
    logic [TAP_W-1:0] idelay_q, idelay_d;
    logic             biterr_q, biterr_d;
    fail_code_e       fail_code_q, fail_code_d;
    logic [TAP_W-1:0] eye_start_q, eye_start_d;
    logic [EYE_W-1:0] eye_len_q, eye_len_d;

    logic             busy;
    logic             trk_clear;
    logic             trk_valid;
    logic [TAP_W-1:0] trk_best_start;
    logic [EYE_W-1:0] trk_best_len;
    logic [TAP_W-1:0] trk_centre;

    surf_eye_tracker u_eye (
        .clk        (aclk),
        .resetn     (aresetn),
        .clear      (trk_clear),
        .valid      (trk_valid),
        .good       (!biterr_q),
        .tap        (tap_q),
        .best_start (trk_best_start),
        .best_len   (trk_best_len),
        .centre     (trk_centre)
    );

    // Next-state logic: sweep, pick the centre, then slip until the training word appears.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tap_d       = tap_q;
        slips_d     = slips_q;
        idelay_d    = idelay_q;
        biterr_d    = biterr_q;
        fail_code_d = fail_code_q;
        eye_start_d = eye_start_q;
        eye_len_d   = eye_len_q;
        trk_clear   = 1'b0;
        trk_valid   = 1'b0;
        busy        = !(state_q inside {ST_IDLE, ST_DONE, ST_FAIL});

        if (busy && !live_i) begin
            state_d     = ST_FAIL;
            fail_code_d = FAIL_ABORT;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (start_i) begin
                        fail_code_d = FAIL_NONE;
                        tap_d       = '0;
                        slips_d     = '0;
                        cnt_d       = '0;
                        eye_start_d = '0;
                        eye_len_d   = '0;
                        trk_clear   = 1'b1;
                        state_d     = ST_SRST;
                    end
                end
                ST_SRST: begin
                    if (cnt_q == SRST_LAST) begin
                        cnt_d    = '0;
                        idelay_d = tap_q;
                        state_d  = ST_LOAD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_LOAD: begin
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_CAP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_CAP: begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt_q == WAIT_LAST) begin
                        cnt_d    = '0;
                        biterr_d = biterr_i;
                        state_d  = ST_EVAL;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_EVAL: begin
                    trk_valid = 1'b1;
                    if (tap_q == {TAP_W{1'b1}}) begin
                        state_d = ST_PICK;
                    end else begin
                        tap_d    = tap_q + 1'b1;
                        idelay_d = tap_q + 1'b1;
                        state_d  = ST_LOAD;
                    end
                end
                ST_PICK: begin
                    eye_start_d = trk_best_start;
                    eye_len_d   = trk_best_len;
                    if (trk_best_len < EYE_MIN) begin
                        fail_code_d = FAIL_NOEYE;
                        state_d     = ST_FAIL;
                    end else begin
                        idelay_d = trk_centre;
                        state_d  = ST_CLOAD;
                    end
                end
                ST_CLOAD: begin
                    cnt_d   = '0;
                    state_d = ST_CSETTLE;
                end
                ST_CSETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_SCAP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_SCAP: begin
                    cnt_d   = '0;
                    state_d = ST_SWAIT;
                end
                ST_SWAIT: begin
                    if (cnt_q == WAIT_LAST) begin
                        cnt_d = '0;
                        if (data_i == TRAIN_SEQUENCE) begin
                            state_d = ST_DONE;
                        end else if (slips_q == SLIP_MAX) begin
                            fail_code_d = FAIL_NOLOCK;
                            state_d     = ST_FAIL;
                        end else begin
                            state_d = ST_SLIP;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_SLIP: begin
                    // First cycle carries the bitslip strobe, the rest let the ISERDES settle.
                    if (cnt_q == '0) begin
                        slips_d = slips_q + 1'b1;
                    end
                    if (cnt_q == SLIP_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_SCAP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            tap_q       <= '0;
            slips_q     <= '0;
            idelay_q    <= '0;
            biterr_q    <= 1'b0;
            fail_code_q <= FAIL_NONE;
            eye_start_q <= '0;
            eye_len_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tap_q       <= tap_d;
            slips_q     <= slips_d;
            idelay_q    <= idelay_d;
            biterr_q    <= biterr_d;
            fail_code_q <= fail_code_d;
            eye_start_q <= eye_start_d;
            eye_len_q   <= eye_len_d;
        end
    end

    // Outputs decoded from state; strobes are gated by live_i so an abort cycle emits none.
    always_comb begin
        iserdes_rst_o  = state_q inside {ST_IDLE, ST_SRST, ST_FAIL};
        idelay_load_o  = live_i && (state_q inside {ST_LOAD, ST_CLOAD});
        capture_o      = live_i && (state_q inside {ST_CAP, ST_SCAP});
        bitslip_o      = live_i && (state_q == ST_SLIP) && (cnt_q == '0);
        busy_o         = busy;
        done_o         = (state_q == ST_DONE);
        fail_o         = (state_q == ST_FAIL);
        fail_code_o    = fail_code_q;
        idelay_value_o = idelay_q;
        eye_start_o    = eye_start_q;
        eye_len_o      = eye_len_q;
    end

endmodule
